ifetch_byte_unit: RTL and testbench

IFETCH_BYTE_UNIT -- requirements
Module: ifetch_byte_unit

---
 rtl/ifetch_pkg.sv | 6 +
 rtl/ifetch_asm_reg.sv | 17 +
 rtl/ifetch_byte_unit.sv | 81 ++++++++
 tb/tb_ifetch_byte_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared FSM state type and constants for the byte-serial instruction fetch unit
package ifetch_pkg;
    typedef enum logic {FETCH, HOLD} state_t;
    localparam int INST_BYTES = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
endpackage

// File: rtl/ifetch_asm_reg.sv
// ifetch_asm_reg: big-endian byte-lane assembly register, lane selected by byte counter
module ifetch_asm_reg
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  cnt,
    input  logic [7:0]  data,
    output logic [31:0] word
);
    // byte 0 lands in the top lane: ~cnt maps 0..3 onto lanes 3..0
    always_ff @(posedge clk) begin
        if (rst) word <= '0;
        else if (we) word[{~cnt, 3'b000} +: 8] <= data;
    end
endmodule

// File: rtl/ifetch_byte_unit.sv
// ifetch_byte_unit: fetches 32-bit instructions one byte per cycle and presents them with a valid/ready handshake
// Optional macro IFETCH_ALIGN_CHECK_EN: reject redirects to non-word-aligned targets and raise sticky misalign_err.
module ifetch_byte_unit
    import ifetch_pkg::*;
#(
    parameter int          IMEM_AW  = 5,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [7:0]         imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    output logic [31:0]        pc_plus4,
    output logic               misalign_err
);
    state_t      state;
    logic [31:0] pc;
    logic [1:0]  cnt;
    logic        redir_ok;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign redir_ok = redirect_valid && (redirect_pc[1:0] == 2'b00);
    // a rejected misaligned redirect latches the error until reset
    always_ff @(posedge clk) begin
        if (rst) misalign_err <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) misalign_err <= 1'b1;
    end
`else
    assign redir_ok = redirect_valid;
    assign misalign_err = 1'b0;
`endif

    // cnt is cleared on entering HOLD, so the same expression yields pc[IMEM_AW-1:0] there
    assign imem_addr = pc[IMEM_AW-1:0] + IMEM_AW'(cnt);

    ifetch_asm_reg u_asm (
        .clk  (clk),
        .rst  (rst),
        .we   (state == FETCH && !redir_ok),
        .cnt  (cnt),
        .data (imem_rdata),
        .word (inst)
    );

    // fetch FSM: reset beats redirect, redirect beats capture and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            cnt        <= 2'd0;
            inst_valid <= 1'b0;
            inst_pc    <= RESET_PC;
            pc_plus4   <= RESET_PC + 32'(INST_BYTES);
        end else if (redir_ok) begin
            state      <= FETCH;
            pc         <= redirect_pc;
            cnt        <= 2'd0;
            inst_valid <= 1'b0;
        end else if (state == FETCH) begin
            if (cnt == 2'(INST_BYTES - 1)) begin
                state      <= HOLD;
                cnt        <= 2'd0;
                inst_valid <= 1'b1;
                inst_pc    <= pc;
                pc_plus4   <= pc + 32'(INST_BYTES);
            end else begin
                cnt <= cnt + 2'd1;
            end
        end else if (inst_ready) begin
            state      <= FETCH;
            pc         <= pc + 32'(INST_BYTES);
            inst_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ifetch_byte_unit.sv
// tb_ifetch_byte_unit: directed self-checking bench for the byte-serial fetch unit
module tb_ifetch_byte_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  imem_addr;
    logic [7:0]  imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;
    logic [7:0]  mem [0:31];
    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;
    assign imem_rdata = mem[imem_addr];

    ifetch_byte_unit #(.IMEM_AW(5), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .pc_plus4       (pc_plus4),
        .misalign_err   (misalign_err)
    );

    function automatic logic [31:0] word_at(int a);
        return {mem[a % 32], mem[(a + 1) % 32], mem[(a + 2) % 32], mem[(a + 3) % 32]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests++; if (inst_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %0b want 0", inst_valid); end
        tests++; if (inst !== 32'h0) begin failed++; $display("FAIL reset_inst got %h want 0", inst); end
        tests++; if (inst_pc !== 32'h0) begin failed++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
        tests++; if (pc_plus4 !== 32'h4) begin failed++; $display("FAIL reset_pc_plus4 got %h want 4", pc_plus4); end
        tests++; if (misalign_err !== 1'b0) begin failed++; $display("FAIL reset_misalign got %0b want 0", misalign_err); end
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        for (int k = 0; k < 4; k++) begin
            tests++; if (imem_addr !== 5'(k)) begin failed++; $display("FAIL first_addr%0d got %h want %h", k, imem_addr, 5'(k)); end
            tests++; if (inst_valid !== 1'b0) begin failed++; $display("FAIL first_early_valid%0d got %0b want 0", k, inst_valid); end
            tick();
        end
        tests++; if (inst_valid !== 1'b1) begin failed++; $display("FAIL first_valid got %0b want 1", inst_valid); end
        tests++; if (inst !== 32'h8C010004) begin failed++; $display("FAIL first_inst got %h want 8c010004", inst); end
        tests++; if (inst_pc !== 32'h0) begin failed++; $display("FAIL first_inst_pc got %h want 0", inst_pc); end
        tests++; if (pc_plus4 !== 32'h4) begin failed++; $display("FAIL first_pc_plus4 got %h want 4", pc_plus4); end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 10; k++) begin
            tick();
            tests++; if (inst_valid !== 1'b1 || inst !== 32'h8C010004 || inst_pc !== 32'h0 || pc_plus4 !== 32'h4 || imem_addr !== 5'h0) begin
                failed++; $display("FAIL stall%0d got v=%0b inst=%h pc=%h p4=%h addr=%h want 1/8c010004/0/4/0", k, inst_valid, inst, inst_pc, pc_plus4, imem_addr);
            end
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tests++; if (inst_valid !== 1'b0) begin failed++; $display("FAIL stall_release_valid got %0b want 0", inst_valid); end
        tests++; if (imem_addr !== 5'h4) begin failed++; $display("FAIL stall_next_addr got %h want 04", imem_addr); end
        repeat (4) tick();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst !== word_at(4) || pc_plus4 !== 32'h8) begin
            failed++; $display("FAIL stall_next_inst got v=%0b pc=%h inst=%h p4=%h want 1/4/%h/8", inst_valid, inst_pc, inst, pc_plus4, word_at(4));
        end
    endtask

    task automatic test_redirect_mid();
        go(32'h8);
        tick();
        tick();
        tests++; if (imem_addr !== 5'h0A) begin failed++; $display("FAIL mid_addr got %h want 0a", imem_addr); end
        go(32'h10);
        tests++; if (inst_valid !== 1'b0 || imem_addr !== 5'h10) begin failed++; $display("FAIL mid_after got v=%0b addr=%h want 0/10", inst_valid, imem_addr); end
        repeat (3) tick();
        tests++; if (inst_valid !== 1'b0) begin failed++; $display("FAIL mid_early_valid got %0b want 0", inst_valid); end
        tick();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst !== word_at(16)) begin
            failed++; $display("FAIL mid_inst got v=%0b pc=%h inst=%h want 1/10/%h", inst_valid, inst_pc, inst, word_at(16));
        end
    endtask

    task automatic test_redirect_handshake();
        go(32'h0);
        repeat (4) tick();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin failed++; $display("FAIL rh_setup got v=%0b pc=%h want 1/0", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        go(32'h8);
        inst_ready = 1'b0;
        tests++; if (inst_valid !== 1'b0 || imem_addr !== 5'h08) begin failed++; $display("FAIL rh_after got v=%0b addr=%h want 0/08", inst_valid, imem_addr); end
        repeat (4) tick();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst !== word_at(8) || pc_plus4 !== 32'hC) begin
            failed++; $display("FAIL rh_inst got v=%0b pc=%h inst=%h p4=%h want 1/8/%h/c", inst_valid, inst_pc, inst, pc_plus4, word_at(8));
        end
    endtask

    task automatic test_hold_drop();
        go(32'h14);
        tests++; if (inst_valid !== 1'b0) begin failed++; $display("FAIL drop_valid got %0b want 0", inst_valid); end
        repeat (4) tick();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h14 || inst !== word_at(20)) begin
            failed++; $display("FAIL drop_inst got v=%0b pc=%h inst=%h want 1/14/%h", inst_valid, inst_pc, inst, word_at(20));
        end
    endtask

    task automatic test_wrap();
        go(32'h1C);
        for (int k = 0; k < 4; k++) begin
            tests++; if (imem_addr !== 5'(28 + k)) begin failed++; $display("FAIL wrap_hi_addr%0d got %h want %h", k, imem_addr, 5'(28 + k)); end
            tick();
        end
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1C || inst !== word_at(28)) begin
            failed++; $display("FAIL wrap_hi_inst got v=%0b pc=%h inst=%h want 1/1c/%h", inst_valid, inst_pc, inst, word_at(28));
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++; if (imem_addr !== 5'(k)) begin failed++; $display("FAIL wrap_lo_addr%0d got %h want %h", k, imem_addr, 5'(k)); end
            tick();
        end
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || inst !== 32'h8C010004 || pc_plus4 !== 32'h24) begin
            failed++; $display("FAIL wrap_lo_inst got v=%0b pc=%h inst=%h p4=%h want 1/20/8c010004/24", inst_valid, inst_pc, inst, pc_plus4);
        end
        go(32'hFFFFFFFC);
        repeat (4) tick();
        tests++; if (inst_pc !== 32'hFFFFFFFC || pc_plus4 !== 32'h0 || inst !== word_at(28)) begin
            failed++; $display("FAIL wrap32_inst got pc=%h p4=%h inst=%h want fffffffc/0/%h", inst_pc, pc_plus4, inst, word_at(28));
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tests++; if (inst_valid !== 1'b0 || imem_addr !== 5'h0) begin failed++; $display("FAIL wrap32_next got v=%0b addr=%h want 0/00", inst_valid, imem_addr); end
    endtask

    task automatic test_misalign();
        go(32'h0);
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h6;
        tick();
        redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || misalign_err !== 1'b1) begin
            failed++; $display("FAIL mis_ignored got v=%0b pc=%h err=%0b want 1/0/1", inst_valid, inst_pc, misalign_err);
        end
        go(32'h4);
        repeat (4) tick();
        tests++; if (misalign_err !== 1'b1 || inst_pc !== 32'h4) begin failed++; $display("FAIL mis_sticky got err=%0b pc=%h want 1/4", misalign_err, inst_pc); end
`else
        tests++; if (inst_valid !== 1'b0 || misalign_err !== 1'b0) begin failed++; $display("FAIL mis_accept got v=%0b err=%0b want 0/0", inst_valid, misalign_err); end
        repeat (4) tick();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h6 || inst !== word_at(6) || misalign_err !== 1'b0) begin
            failed++; $display("FAIL mis_inst got v=%0b pc=%h inst=%h err=%0b want 1/6/%h/0", inst_valid, inst_pc, inst, misalign_err, word_at(6));
        end
`endif
    endtask

    task automatic test_reset_midfetch();
        go(32'h10);
        tick();
        tick();
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8;
        inst_ready = 1'b1;
        tick();
        rst = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        tests++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || pc_plus4 !== 32'h4 || imem_addr !== 5'h0 || misalign_err !== 1'b0) begin
            failed++; $display("FAIL rst_mid got v=%0b inst=%h pc=%h p4=%h addr=%h err=%0b want 0/0/0/4/00/0", inst_valid, inst, inst_pc, pc_plus4, imem_addr, misalign_err);
        end
        repeat (4) tick();
        tests++; if (inst_valid !== 1'b1 || inst !== 32'h8C010004 || inst_pc !== 32'h0) begin
            failed++; $display("FAIL rst_refetch got v=%0b inst=%h pc=%h want 1/8c010004/0", inst_valid, inst, inst_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(8'h30 + i * 7);
        mem[0] = 8'h8C;
        mem[1] = 8'h01;
        mem[2] = 8'h00;
        mem[3] = 8'h04;
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_mid();
        test_redirect_handshake();
        test_hold_drop();
        test_wrap();
        test_misalign();
        test_reset_midfetch();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
